// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer: FSM state encoding,
// default widths, and the zero-step-means-one rule.
package count_seq_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_WRAP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A programmed step of zero would stall a run forever, so it advances by one.
  function automatic logic [31:0] eff_step(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/seq_value_reg.sv
// Value register owned by the sequencer: loads d_in when en is high.
// Latency: one cycle from en to q; no backpressure, it always accepts.
module seq_value_reg
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d_in;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequences the value register through load / step / wrap-or-stop runs.
// Latency: value follows a command by one cycle; pause freezes the count (no other backpressure).
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              cont,
  input  logic [WIDTH-1:0]  starting,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  match_val,
  output logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic              match_hit,
  output logic [WRAP_W-1:0] wraps
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]  start_sh;
  logic [WIDTH-1:0]  limit_sh;
  logic [STEP_W-1:0] step_sh;
  logic              cont_sh;

  logic [WRAP_W-1:0] wraps_q;
  logic              match_q;

  logic              capture;
  logic              wrap_inc;
  logic              en;
  logic [WIDTH-1:0]  d_in;

  logic [WIDTH:0]    step_ext;
  logic [WIDTH:0]    sum;
  logic              over;

  // One extra bit keeps limit = all-ones reachable without rolling over to 0.
  assign step_ext = (WIDTH+1)'(eff_step(32'(step_sh)));
  assign sum      = {1'b0, value} + step_ext;
  assign over     = sum > {1'b0, limit_sh};

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    wrap_inc = 1'b0;
    en       = 1'b0;
    d_in     = value;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          capture = 1'b1;
          en      = 1'b1;
          d_in    = starting;
          state_d = (starting > limit) ? DONE : RUN;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (!over) begin
          en      = 1'b1;
          d_in    = sum[WIDTH-1:0];
          state_d = RUN;
        end else if (cont_sh) begin
          en       = 1'b1;
          d_in     = start_sh;
          wrap_inc = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run configuration is frozen at start; port changes mid-run are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sh <= '0;
      limit_sh <= '0;
      step_sh  <= '0;
      cont_sh  <= 1'b0;
    end else if (capture) begin
      start_sh <= starting;
      limit_sh <= limit;
      step_sh  <= step;
      cont_sh  <= cont;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wraps_q <= '0;
    end else if (capture) begin
      wraps_q <= '0;
    end else if (wrap_inc && (wraps_q != '1)) begin
      wraps_q <= wraps_q + WRAP_W'(1);
    end
  end

  // Flag follows the write that lands in the register, so hold cycles clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= en && (d_in == match_val);
    end
  end

  seq_value_reg #(
    .WIDTH (WIDTH)
  ) u_value_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d_in  (d_in),
    .q     (value)
  );

  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign done      = (state_q == DONE);
  assign match_hit = match_q;
  assign wraps     = wraps_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios with literal expectations plus
// randomized commands, all outputs compared each cycle against a behavioural model.
module tb_count_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        pause;
  logic        cont;
  logic [15:0] starting;
  logic [15:0] limit;
  logic [3:0]  step;
  logic [15:0] match_val;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        match_hit;
  logic [7:0]  wraps;

  int n_checks = 0;
  int n_errors = 0;

  count_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cont      (cont),
    .starting  (starting),
    .limit     (limit),
    .step      (step),
    .match_val (match_val),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .match_hit (match_hit),
    .wraps     (wraps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: modes, run config and counts kept as plain integers.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  int          m_mode;
  int unsigned m_value;
  int unsigned m_wraps;
  bit          m_match;
  int unsigned sh_start;
  int unsigned sh_lim;
  int unsigned sh_step;
  bit          sh_cont;

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_value  = 0;
    m_wraps  = 0;
    m_match  = 1'b0;
    sh_start = 0;
    sh_lim   = 0;
    sh_step  = 1;
    sh_cont  = 1'b0;
  endtask

  task automatic model_step();
    bit          wrote;
    int unsigned nxt;
    wrote = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (start && !stop) begin
          sh_start = starting;
          sh_lim   = limit;
          sh_step  = (step == 4'd0) ? 1 : int'(step);
          sh_cont  = cont;
          m_value  = starting;
          m_wraps  = 0;
          wrote    = 1'b1;
          m_mode   = (starting > limit) ? M_DONE : M_RUN;
        end
      end
      M_RUN, M_PAUSE: begin
        if (stop) begin
          m_mode = M_IDLE;
        end else if (pause) begin
          m_mode = M_PAUSE;
        end else begin
          nxt    = m_value + sh_step;
          m_mode = M_RUN;
          if (nxt <= sh_lim) begin
            m_value = nxt;
            wrote   = 1'b1;
          end else if (sh_cont) begin
            m_value = sh_start;
            wrote   = 1'b1;
            if (m_wraps < 255) m_wraps++;
          end else begin
            m_mode = M_DONE;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_match = wrote && (m_value == int'(match_val));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare process: every output against the model, once per cycle.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_value", 32'(value), m_value);
      check("cmp_busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_PAUSE)));
      check("cmp_done", 32'(done), 32'(m_mode == M_DONE));
      check("cmp_match", 32'(match_hit), 32'(m_match));
      check("cmp_wraps", 32'(wraps), m_wraps);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] l, input logic [3:0] st,
                       input logic c, input logic [15:0] m);
    starting  = s;
    limit     = l;
    step      = st;
    cont      = c;
    match_val = m;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    setup(16'd0, 16'd0, 4'd0, 1'b0, 16'd0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wraps", 32'(wraps), 32'd0);

    // Single pass 0..9
    setup(16'd0, 16'd9, 4'd1, 1'b0, 16'd9);
    start = 1'b1;
    tick(); start = 1'b0;
    check("t1_first", 32'(value), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t1_value", 32'(value), 32'(i));
      check("t1_match", 32'(match_hit), 32'(i == 9));
    end
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_done_value", 32'(value), 32'd9);
    tick();
    check("t1_idle_done", 32'(done), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Pause for three cycles: count slips by three
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    check("p_pre", 32'(value), 32'd3);
    pause = 1'b1;
    tick(); check("p_hold1", 32'(value), 32'd3);
    tick(); check("p_hold2", 32'(value), 32'd3);
    tick(); pause = 1'b0;
    check("p_hold3", 32'(value), 32'd3);
    tick(); check("p_resume", 32'(value), 32'd4);
    repeat (5) tick();
    check("p_last", 32'(value), 32'd9);
    check("p_nodone", 32'(done), 32'd0);
    tick(); check("p_done", 32'(done), 32'd1);
    tick();

    // Stop mid-run
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("s_busy", 32'(busy), 32'd0);
    check("s_value", 32'(value), 32'd4);
    check("s_done", 32'(done), 32'd0);
    tick(); check("s_done2", 32'(done), 32'd0);

    // Top of range, step 0 acts as 1, limit change mid-run ignored
    setup(16'hFFF0, 16'hFFFF, 4'd0, 1'b0, 16'hFFFF);
    start = 1'b1;
    tick(); start = 1'b0;
    check("h_first", 32'(value), 32'hFFF0);
    repeat (3) tick();
    limit = 16'hFFF5;
    repeat (12) tick();
    check("h_last", 32'(value), 32'hFFFF);
    check("h_match", 32'(match_hit), 32'd1);
    check("h_busy", 32'(busy), 32'd1);
    tick();
    check("h_done", 32'(done), 32'd1);
    check("h_nowrap", 32'(value), 32'hFFFF);
    tick();

    // Continuous wrap and saturation
    setup(16'd2, 16'd10, 4'd3, 1'b1, 16'd8);
    start = 1'b1;
    tick(); start = 1'b0;
    check("w_v0", 32'(value), 32'd2);
    tick(); check("w_v1", 32'(value), 32'd5);
    tick(); check("w_v2", 32'(value), 32'd8);
    check("w_match", 32'(match_hit), 32'd1);
    tick(); check("w_v3", 32'(value), 32'd2);
    check("w_wraps1", 32'(wraps), 32'd1);
    repeat (1800) tick();
    check("w_sat", 32'(wraps), 32'd255);
    check("w_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("w_stop_busy", 32'(busy), 32'd0);
    check("w_stop_wraps", 32'(wraps), 32'd255);

    // starting > limit: straight to DONE; start during DONE ignored
    setup(16'd20, 16'd10, 4'd1, 1'b0, 16'd20);
    start = 1'b1;
    tick();
    check("g_done", 32'(done), 32'd1);
    check("g_value", 32'(value), 32'd20);
    check("g_match", 32'(match_hit), 32'd1);
    tick(); start = 1'b0;
    check("g_ignored", 32'(busy), 32'd0);
    check("g_idle_done", 32'(done), 32'd0);

    // start and stop together: stays IDLE
    setup(16'd5, 16'd50, 4'd1, 1'b0, 16'd0);
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_value", 32'(value), 32'd20);

    // start while busy ignored
    start = 1'b1;
    tick(); start = 1'b0;
    check("b_v0", 32'(value), 32'd5);
    starting = 16'd30; start = 1'b1;
    tick(); start = 1'b0;
    check("b_v1", 32'(value), 32'd6);
    stop = 1'b1;
    tick(); stop = 1'b0;

    // Asynchronous reset mid-run
    setup(16'd2, 16'd10, 4'd3, 1'b1, 16'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (12) tick();
    #1 reset = 1'b1;
    #1;
    check("ar_value", 32'(value), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_wraps", 32'(wraps), 32'd0);
    check("ar_match", 32'(match_hit), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    tick(); tick();
    reset = 1'b0;
    setup(16'd7, 16'd9, 4'd1, 1'b0, 16'd8);
    start = 1'b1;
    tick(); start = 1'b0;
    check("ar_v0", 32'(value), 32'd7);
    tick(); check("ar_v1", 32'(value), 32'd8);
    tick(); check("ar_v2", 32'(value), 32'd9);
    tick(); check("ar_done2", 32'(done), 32'd1);
    tick();

    // Randomized commands against the model
    repeat (3000) begin
      start     = ($urandom_range(2) == 0);
      stop      = ($urandom_range(19) == 0);
      pause     = ($urandom_range(7) == 0);
      cont      = ($urandom_range(1) == 1);
      starting  = 16'($urandom_range(40));
      limit     = 16'($urandom_range(60));
      step      = 4'($urandom_range(15));
      match_val = 16'($urandom_range(60));
      tick();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
